// File: rtl/bin_to_onehot_stream_pkg.sv
// Shared types and helpers for the binary-to-one-hot stream decoder.
package bin_to_onehot_pkg;

   // FULL is the single-entry name for the one-beat-stored state.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } fsm_state_e;

   localparam fsm_state_e FULL = ONE;

   function automatic logic in_range(input int unsigned idx, input int unsigned width);
      return idx < width;
   endfunction

endpackage

// File: rtl/bin_to_onehot_stream_if.sv
// Valid/ready stream bundle for bin_to_onehot_stream: index in, one-hot plus error out.
interface bin_to_onehot_stream_if #(
   parameter int ONEHOT_WIDTH = 16,
   parameter int BIN_WIDTH    = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH)
);
   logic                    clear_i;
   logic                    valid_i;
   logic                    ready_o;
   logic [BIN_WIDTH-1:0]    bin_i;
   logic                    valid_o;
   logic                    ready_i;
   logic [ONEHOT_WIDTH-1:0] onehot_o;
   logic                    err_o;
   logic                    err_sticky_o;

   modport master (
      output clear_i, valid_i, bin_i, ready_i,
      input  ready_o, valid_o, onehot_o, err_o, err_sticky_o
   );

   modport slave (
      input  clear_i, valid_i, bin_i, ready_i,
      output ready_o, valid_o, onehot_o, err_o, err_sticky_o
   );
endinterface

// File: rtl/bin_to_onehot_stream_dec.sv
// Combinational index decoder: one-hot vector plus out-of-range flag.
module bin_to_onehot_dec
   import bin_to_onehot_pkg::*;
#(
   parameter int ONEHOT_WIDTH = 16,
   parameter int BIN_WIDTH    = 4
) (
   input  logic [BIN_WIDTH-1:0]    bin_i,
   output logic [ONEHOT_WIDTH-1:0] onehot_o,
   output logic                    err_o
);
   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < ONEHOT_WIDTH; i++) begin
         onehot_o[i] = (32'(bin_i) == 32'(i));
      end
      err_o = !in_range(32'(bin_i), 32'(ONEHOT_WIDTH));
   end
endmodule

// File: rtl/bin_to_onehot_stream.sv
// Registered valid/ready binary-to-one-hot decoder. Define BIN_TO_ONEHOT_STREAM_SKID_EN
// for a two-entry skid buffer with registered ready_o; otherwise a single-entry stage.
//
// state | meaning
// EMPTY | no beat stored
// ONE   | one beat stored (FULL in the single-entry build)
// TWO   | head and tail both stored (skid build only)
module bin_to_onehot_stream
   import bin_to_onehot_pkg::*;
#(
   parameter  int ONEHOT_WIDTH = 16,
   localparam int BIN_WIDTH    = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   bin_to_onehot_stream_if.slave   bus
);
   logic [ONEHOT_WIDTH-1:0] dec_onehot;
   logic                    dec_err;
   logic [ONEHOT_WIDTH:0]   beat_in;
   logic [ONEHOT_WIDTH:0]   head_q, head_d;
   fsm_state_e              state_q, state_d;
   logic                    sticky_q, sticky_d;
   logic                    accept, pop;

   bin_to_onehot_dec #(
      .ONEHOT_WIDTH (ONEHOT_WIDTH),
      .BIN_WIDTH    (BIN_WIDTH)
   ) u_dec (
      .bin_i    (bus.bin_i),
      .onehot_o (dec_onehot),
      .err_o    (dec_err)
   );

   // Stored beat layout is {err, onehot}.
   assign beat_in          = {dec_err, dec_onehot};
   assign accept           = bus.valid_i & bus.ready_o;
   assign pop              = bus.valid_o & bus.ready_i;
   assign bus.valid_o      = (state_q != EMPTY);
   assign bus.onehot_o     = bus.valid_o ? head_q[ONEHOT_WIDTH-1:0] : '0;
   assign bus.err_o        = bus.valid_o & head_q[ONEHOT_WIDTH];
   assign bus.err_sticky_o = sticky_q;

`ifdef BIN_TO_ONEHOT_STREAM_SKID_EN
   logic [ONEHOT_WIDTH:0] tail_q, tail_d;
   logic                  ready_q, ready_d;

   assign bus.ready_o = ready_q & ~bus.clear_i;

   always_comb begin
      state_d  = state_q;
      head_d   = head_q;
      tail_d   = tail_q;
      sticky_d = sticky_q | (accept & dec_err);
      if (bus.clear_i) begin
         state_d  = EMPTY;
         sticky_d = 1'b0;
      end else begin
         unique case (state_q)
            EMPTY: if (accept) begin
               state_d = ONE;
               head_d  = beat_in;
            end
            ONE: begin
               if (accept && pop) begin
                  head_d = beat_in;
               end else if (accept) begin
                  state_d = TWO;
                  tail_d  = beat_in;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            TWO: if (pop) begin
               state_d = ONE;
               head_d  = tail_q;
            end
            default: state_d = EMPTY;
         endcase
      end
      ready_d = (state_d != TWO);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= EMPTY;
         head_q   <= '0;
         tail_q   <= '0;
         sticky_q <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         sticky_q <= sticky_d;
         ready_q  <= ready_d;
      end
   end
`else
   // A pop frees the slot in the same cycle, so ready_o looks through to ready_i.
   assign bus.ready_o = ~bus.clear_i & ((state_q == EMPTY) | bus.ready_i);

   always_comb begin
      state_d  = state_q;
      head_d   = head_q;
      sticky_d = sticky_q | (accept & dec_err);
      if (bus.clear_i) begin
         state_d  = EMPTY;
         sticky_d = 1'b0;
      end else if (accept) begin
         state_d = FULL;
         head_d  = beat_in;
      end else if (pop) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= EMPTY;
         head_q   <= '0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         head_q   <= head_d;
         sticky_q <= sticky_d;
      end
   end
`endif
endmodule

// File: tb/tb_bin_to_onehot_stream.sv
// Drives a 16-wide and a 10-wide decoder with identical streams and checks both
// against a queue-based reference of the stream behaviour.
module tb_bin_to_onehot_stream;
`ifdef BIN_TO_ONEHOT_STREAM_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bin_to_onehot_stream_if #(.ONEHOT_WIDTH(16)) bus16 ();
   bin_to_onehot_stream_if #(.ONEHOT_WIDTH(10)) bus10 ();

   bin_to_onehot_stream #(.ONEHOT_WIDTH(16)) u_dut16 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus16)
   );

   bin_to_onehot_stream #(.ONEHOT_WIDTH(10)) u_dut10 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus10)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   int   q16[$];
   int   q10[$];
   logic sticky16 = 1'b0;
   logic sticky10 = 1'b0;
   logic acc;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_onehot(input int idx, input int width);
      return (idx < width) ? (32'd1 << idx) : 32'd0;
   endfunction

   function automatic logic ref_ready(input int used, input logic rdy, input logic clr);
      if (clr) return 1'b0;
      if (DEPTH == 1) return (used == 0) || rdy;
      return used < DEPTH;
   endfunction

   task automatic check_all(input logic exp_rdy);
      int h16, h10;
      logic v16, v10;
      v16 = (q16.size() > 0);
      v10 = (q10.size() > 0);
      h16 = v16 ? q16[0] : 0;
      h10 = v10 ? q10[0] : 0;
      check_eq("valid16",  bus16.valid_o, v16);
      check_eq("onehot16", bus16.onehot_o, v16 ? ref_onehot(h16, 16) : 32'd0);
      check_eq("err16",    bus16.err_o, v16 && (h16 >= 16));
      check_eq("sticky16", bus16.err_sticky_o, sticky16);
      check_eq("ready16",  bus16.ready_o, exp_rdy);
      check_eq("valid10",  bus10.valid_o, v10);
      check_eq("onehot10", bus10.onehot_o, v10 ? ref_onehot(h10, 10) : 32'd0);
      check_eq("err10",    bus10.err_o, v10 && (h10 >= 10));
      check_eq("sticky10", bus10.err_sticky_o, sticky10);
      check_eq("ready10",  bus10.ready_o, exp_rdy);
   endtask

   task automatic drive(input logic v, input logic [3:0] b, input logic r, input logic c);
      bus16.valid_i = v; bus16.bin_i = b; bus16.ready_i = r; bus16.clear_i = c;
      bus10.valid_i = v; bus10.bin_i = b; bus10.ready_i = r; bus10.clear_i = c;
   endtask

   // Called just after a rising edge; returns whether the beat was taken.
   task automatic step(input logic v, input logic [3:0] b, input logic r, input logic c,
                       output logic accepted);
      logic rdy;
      drive(v, b, r, c);
      @(negedge clk);
      rdy = ref_ready(q16.size(), r, c);
      check_all(rdy);
      accepted = v & rdy;
      @(posedge clk);
      if (c) begin
         q16.delete();
         q10.delete();
         sticky16 = 1'b0;
         sticky10 = 1'b0;
      end else begin
         if (q16.size() > 0 && r) begin
            void'(q16.pop_front());
            void'(q10.pop_front());
         end
         if (accepted) begin
            q16.push_back(int'(b));
            q10.push_back(int'(b));
            if (int'(b) >= 10) sticky10 = 1'b1;
         end
      end
      #1;
   endtask

   task automatic async_reset();
      drive(1'b1, 4'd4, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      q16.delete();
      q10.delete();
      sticky16 = 1'b0;
      sticky10 = 1'b0;
      check_all(1'b1);
      @(posedge clk);
      @(posedge clk);
      drive(1'b0, 4'd0, 1'b1, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sent;
      rst_n = 1'b0;
      drive(1'b0, 4'd0, 1'b1, 1'b0);
      #12;
      check_all(1'b1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      step(1'b1, 4'd5, 1'b1, 1'b0, acc);
      step(1'b0, 4'd0, 1'b1, 1'b0, acc);
      check_eq("bin5_onehot16", bus16.onehot_o, 32'h0);

      for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b1, 1'b0, acc);
      step(1'b0, 4'd0, 1'b1, 1'b0, acc);
      step(1'b0, 4'd0, 1'b1, 1'b0, acc);

      sent = 0;
      for (int k = 0; k < 10; k++) begin
         step(sent < 2, (sent == 0) ? 4'd3 : 4'd7, k >= 4, 1'b0, acc);
         if (acc) sent++;
      end
      check_eq("bp_both_sent", 32'(sent), 32'd2);

      step(1'b1, 4'd12, 1'b0, 1'b0, acc);
      for (int k = 0; k < 3; k++) step(1'b0, 4'd0, 1'b0, 1'b0, acc);
      step(1'b1, 4'd2, 1'b0, 1'b1, acc);
      step(1'b0, 4'd0, 1'b1, 1'b0, acc);
      step(1'b0, 4'd0, 1'b1, 1'b0, acc);

      for (int k = 0; k < 400; k++)
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, acc);

      step(1'b1, 4'd9, 1'b0, 1'b0, acc);
      step(1'b0, 4'd0, 1'b0, 1'b0, acc);
      check_eq("pre_reset_valid16", bus16.valid_o, 32'd1);
      async_reset();
      step(1'b1, 4'd1, 1'b1, 1'b0, acc);
      step(1'b0, 4'd0, 1'b1, 1'b0, acc);

      for (int k = 0; k < 200; k++)
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              $urandom_range(0, 9) < 5, $urandom_range(0, 49) == 0, acc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
